cmos_gate_probe: RTL

Sequential stimulus driver and checker for the transistor-level two-input gates in the optional CMOS levels. It is the driving side of a gate's `a`/`b`/`o` interface. On a `start` pulse it applies all four input vectors to a gate under test, waits a programmable settle time per vector, and samples the gate output. It compares each sample against an expected truth table and reports pass/fail with a mismatch count. It sits in the bench/self-test layer alongside the CMOS gate models.

---
 rtl/cmos_gate_probe.sv | 125 ++++++++++++
 1 files changed

// File: rtl/cmos_gate_probe.sv
// Sweeps all four {a,b} vectors into a two-input gate, samples its output after a settle
// window and checks it against TT. Optional first-mismatch capture: CMOS_GATE_PROBE_FAILCAP_EN.
module cmos_gate_probe #(
   parameter int unsigned SETTLE = 2,
   parameter logic [3:0]  TT     = 4'b0111
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       obs,
   output logic       drv_a,
   output logic       drv_b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] fail_cnt,
   output logic [1:0] fail_vec
);

   localparam logic [3:0] SettleCnt = 4'(SETTLE);

   typedef enum logic {StIdle, StSettle} state_e;

   state_e     state_q, state_d;
   logic [1:0] vec_q, vec_d;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] fail_cnt_q, fail_cnt_d;
   logic       pass_q, pass_d;
   logic       done_q, done_d;
   logic       mismatch;

   // Case inequality so an X/Z output from the gate model is a mismatch.
   assign mismatch = (obs !== TT[vec_q]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         vec_q      <= 2'b00;
         cnt_q      <= 4'd0;
         fail_cnt_q <= 3'd0;
         pass_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         vec_q      <= vec_d;
         cnt_q      <= cnt_d;
         fail_cnt_q <= fail_cnt_d;
         pass_q     <= pass_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      vec_d      = vec_q;
      cnt_d      = cnt_q;
      fail_cnt_d = fail_cnt_q;
      pass_d     = pass_q;
      done_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d    = StSettle;
               vec_d      = 2'b00;
               cnt_d      = SettleCnt;
               fail_cnt_d = 3'd0;
               pass_d     = 1'b0;
            end
         end
         StSettle: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               if (mismatch) begin
                  fail_cnt_d = fail_cnt_q + 3'd1;
               end
               if (vec_q != 2'd3) begin
                  vec_d = vec_q + 2'd1;
                  cnt_d = SettleCnt;
               end else begin
                  // Drive stays at 11 after the sweep until the next start.
                  state_d = StIdle;
                  done_d  = 1'b1;
                  pass_d  = (fail_cnt_d == 3'd0);
               end
            end
         end
      endcase
   end

`ifdef CMOS_GATE_PROBE_FAILCAP_EN
   logic [1:0] fail_vec_q, fail_vec_d;

   always_comb begin
      fail_vec_d = fail_vec_q;
      if (state_q == StIdle) begin
         if (start) begin
            fail_vec_d = 2'b00;
         end
      end else if (cnt_q == 4'd0 && mismatch && fail_cnt_q == 3'd0) begin
         fail_vec_d = vec_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail_vec_q <= 2'b00;
      end else begin
         fail_vec_q <= fail_vec_d;
      end
   end

   assign fail_vec = fail_vec_q;
`else
   assign fail_vec = 2'b00;
`endif

   assign drv_a    = vec_q[1];
   assign drv_b    = vec_q[0];
   assign busy     = (state_q == StSettle);
   assign done     = done_q;
   assign pass     = pass_q;
   assign fail_cnt = fail_cnt_q;

endmodule
